// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_pipe_reg
// Brief    : ID/EX pipeline register with stall hold, flush bubbles and a
//            saturating bubble counter.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [6:0]         id_ctrl,
  input  logic [1:0]         id_alu_op,
  input  logic [2:0]         id_funct3,
  input  logic [6:0]         id_funct7,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic [DATA_W-1:0]  id_rd1,
  input  logic [DATA_W-1:0]  id_rd2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  output logic               ex_valid,
  output logic [6:0]         ex_ctrl,
  output logic [1:0]         ex_alu_op,
  output logic [2:0]         ex_funct3,
  output logic [6:0]         ex_funct7,
  output logic [DATA_W-1:0]  ex_pc,
  output logic [DATA_W-1:0]  ex_rd1,
  output logic [DATA_W-1:0]  ex_rd2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [RADDR_W-1:0] ex_rs1,
  output logic [RADDR_W-1:0] ex_rs2,
  output logic [RADDR_W-1:0] ex_rd,
  output logic [15:0]        ex_bubble_cnt
);

  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  logic               r_valid;
  logic [6:0]         r_ctrl;
  logic [1:0]         r_alu_op;
  logic [2:0]         r_funct3;
  logic [6:0]         r_funct7;
  logic [DATA_W-1:0]  r_pc;
  logic [DATA_W-1:0]  r_rd1;
  logic [DATA_W-1:0]  r_rd2;
  logic [DATA_W-1:0]  r_imm;
  logic [RADDR_W-1:0] r_rs1;
  logic [RADDR_W-1:0] r_rs2;
  logic [RADDR_W-1:0] r_rd;
  logic [15:0]        r_bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_ctrl       <= '0;
      r_alu_op     <= '0;
      r_funct3     <= '0;
      r_funct7     <= '0;
      r_pc         <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_bubble_cnt <= '0;
    end else if (flush) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;
      r_alu_op <= '0;
      r_funct3 <= '0;
      r_funct7 <= '0;
      r_pc     <= '0;
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_imm    <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      if (r_bubble_cnt != c_cnt_max) begin
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
    end else if (!stall) begin
      // A non-instruction must never carry control side effects into EX.
      r_valid  <= id_valid;
      r_ctrl   <= id_valid ? id_ctrl : 7'd0;
      r_alu_op <= id_alu_op;
      r_funct3 <= id_funct3;
      r_funct7 <= id_funct7;
      r_pc     <= id_pc;
      r_rd1    <= id_rd1;
      r_rd2    <= id_rd2;
      r_imm    <= id_imm;
      r_rs1    <= id_rs1;
      r_rs2    <= id_rs2;
      r_rd     <= id_rd;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_ctrl       = r_ctrl;
  assign ex_alu_op     = r_alu_op;
  assign ex_funct3     = r_funct3;
  assign ex_funct7     = r_funct7;
  assign ex_pc         = r_pc;
  assign ex_rd1        = r_rd1;
  assign ex_rd2        = r_rd2;
  assign ex_imm        = r_imm;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;
  assign ex_bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_pipe_reg
// Brief    : Self-checking bench for id_ex_pipe_reg (reference model + directed).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_pipe_reg;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int c_all_w = 1 + 7 + 2 + 3 + 7 + 4 * DATA_W + 3 * RADDR_W + 16;

  logic               clk;
  logic               rst_n;
  logic               stall;
  logic               flush;
  logic               id_valid;
  logic [6:0]         id_ctrl;
  logic [1:0]         id_alu_op;
  logic [2:0]         id_funct3;
  logic [6:0]         id_funct7;
  logic [DATA_W-1:0]  id_pc;
  logic [DATA_W-1:0]  id_rd1;
  logic [DATA_W-1:0]  id_rd2;
  logic [DATA_W-1:0]  id_imm;
  logic [RADDR_W-1:0] id_rs1;
  logic [RADDR_W-1:0] id_rs2;
  logic [RADDR_W-1:0] id_rd;
  logic               ex_valid;
  logic [6:0]         ex_ctrl;
  logic [1:0]         ex_alu_op;
  logic [2:0]         ex_funct3;
  logic [6:0]         ex_funct7;
  logic [DATA_W-1:0]  ex_pc;
  logic [DATA_W-1:0]  ex_rd1;
  logic [DATA_W-1:0]  ex_rd2;
  logic [DATA_W-1:0]  ex_imm;
  logic [RADDR_W-1:0] ex_rs1;
  logic [RADDR_W-1:0] ex_rs2;
  logic [RADDR_W-1:0] ex_rd;
  logic [15:0]        ex_bubble_cnt;

  int checks   = 0;
  int failures = 0;

  id_ex_pipe_reg #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .id_alu_op(id_alu_op),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_pc(id_pc),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_alu_op(ex_alu_op),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_pc(ex_pc),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_bubble_cnt(ex_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the EX contents as a record plus a plain flush tally.
  typedef struct packed {
    logic               valid;
    logic [6:0]         ctrl;
    logic [1:0]         alu_op;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  rd1;
    logic [DATA_W-1:0]  rd2;
    logic [DATA_W-1:0]  imm;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
  } ex_rec_t;

  ex_rec_t m_ex;
  int      m_flushes;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex      <= '0;
      m_flushes <= 0;
    end else if (flush) begin
      m_ex      <= '0;
      m_flushes <= m_flushes + 1;
    end else if (!stall) begin
      m_ex <= '{valid: id_valid, ctrl: (id_valid ? id_ctrl : 7'd0),
                alu_op: id_alu_op, funct3: id_funct3, funct7: id_funct7,
                pc: id_pc, rd1: id_rd1, rd2: id_rd2, imm: id_imm,
                rs1: id_rs1, rs2: id_rs2, rd: id_rd};
    end
  end

  function automatic logic [15:0] exp_cnt(input int n);
    return (n >= 65535) ? 16'hFFFF : n[15:0];
  endfunction

  task automatic check(input string name, input logic [c_all_w-1:0] act,
                       input logic [c_all_w-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  wire [c_all_w-1:0] w_dut_all = {ex_valid, ex_ctrl, ex_alu_op, ex_funct3, ex_funct7,
                                  ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
                                  ex_bubble_cnt};

  always @(posedge clk) begin
    #2;
    check("model_cycle", w_dut_all, {m_ex, exp_cnt(m_flushes)});
  end

  task automatic set_instr(input logic v, input logic [6:0] c, input logic [1:0] op,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] pc, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm,
                           input logic [4:0] s1, input logic [4:0] s2,
                           input logic [4:0] d);
    id_valid = v; id_ctrl = c; id_alu_op = op; id_funct3 = f3; id_funct7 = f7;
    id_pc = pc; id_rd1 = a; id_rd2 = b; id_imm = imm;
    id_rs1 = s1; id_rs2 = s2; id_rd = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_instr(1'b0, 7'd0, 2'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    tick(); tick();
    check("reset_all_zero", w_dut_all, '0);
    @(negedge clk); rst_n = 1'b1;

    // SUB x7, x1, x2 with rd1=5, rd2=3
    set_instr(1'b1, 7'b1000000, 2'b10, 3'b000, 7'b0100000, 32'h100, 32'd5, 32'd3,
              32'd0, 5'd1, 5'd2, 5'd7);
    tick();
    check("load_valid", {ex_valid, ex_alu_op, ex_funct7}, {1'b1, 2'b10, 7'b0100000});
    check("load_data", {ex_rd1, ex_rd2, ex_rd, ex_ctrl}, {32'd5, 32'd3, 5'd7, 7'b1000000});

    // ADD waiting in ID while stalled
    @(negedge clk);
    stall = 1'b1;
    set_instr(1'b1, 7'b1000000, 2'b10, 3'b000, 7'b0000000, 32'h104, 32'd10, 32'd20,
              32'd0, 5'd3, 5'd4, 5'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", {ex_funct7, ex_rd, ex_rd1, ex_pc}, {7'b0100000, 5'd7, 32'd5, 32'h100});
    end
    @(negedge clk); stall = 1'b0;
    tick();
    check("stall_release", {ex_funct7, ex_rd, ex_rd1, ex_pc}, {7'b0000000, 5'd9, 32'd10, 32'h104});

    @(negedge clk); stall = 1'b1; flush = 1'b1;
    tick();
    check("flush_over_stall", {ex_valid, ex_ctrl, ex_alu_op, ex_rd1, ex_bubble_cnt},
          {1'b0, 7'd0, 2'b00, 32'd0, 16'd1});

    @(negedge clk); stall = 1'b0; flush = 1'b0;
    set_instr(1'b0, 7'h7F, 2'b11, 3'b111, 7'h7F, 32'hFFFF_FFFC, 32'hDEAD_BEEF,
              32'h8000_0000, 32'hFFFF_F800, 5'd31, 5'd30, 5'd29);
    tick();
    check("invalid_id", {ex_valid, ex_ctrl, ex_bubble_cnt, ex_rd1, ex_alu_op},
          {1'b0, 7'd0, 16'd1, 32'hDEAD_BEEF, 2'b11});

    // Async reset in mid-cycle while stalled and flushing, EX holding a valid op
    @(negedge clk);
    set_instr(1'b1, 7'b0110100, 2'b00, 3'b010, 7'd0, 32'h200, 32'h40, 32'h0,
              32'h8, 5'd5, 5'd0, 5'd6);
    tick();
    check("pre_reset_valid", {ex_valid, ex_ctrl}, {1'b1, 7'b0110100});
    stall = 1'b1; flush = 1'b1;
    rst_n = 1'b0;
    #1;
    check("async_reset", w_dut_all, '0);
    @(negedge clk); rst_n = 1'b1; stall = 1'b0;

    // flush stays high: drive the counter to saturation
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #3;
    check("cnt_65534", {16'd0, ex_bubble_cnt}, {16'd0, 16'hFFFE});
    tick();
    check("cnt_sat", {16'd0, ex_bubble_cnt}, {16'd0, 16'hFFFF});
    for (int i = 0; i < 3; i++) tick();
    check("cnt_no_wrap", {16'd0, ex_bubble_cnt}, {16'd0, 16'hFFFF});

    @(negedge clk); flush = 1'b0;
    set_instr(1'b1, 7'b1000011, 2'b11, 3'b101, 7'b1010101, 32'hFFFF_FFFF, 32'h1234_5678,
              32'h9ABC_DEF0, 32'hFFFF_FFFF, 5'd17, 5'd18, 5'd19);
    tick();
    check("post_sat_load", {ex_valid, ex_ctrl, ex_funct3, ex_imm, ex_bubble_cnt},
          {1'b1, 7'b1000011, 3'b101, 32'hFFFF_FFFF, 16'hFFFF});
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
